// File: rtl/cache_tag_array_nway.sv
// cache_tag_array_nway: N-way set-associative tag store with valid/dirty bits,
// a per-set round-robin victim pointer, and an invalidate-all walker.
//
// Optional macro TAG_ARRAY_BYPASS_EN: a request accepted right after a write
// to the same set sees the committed write. Without the macro, that request
// sees the pre-write contents, as a raw SRAM would.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   csb, web          active-low select / active-low write
//   addr              set index
//   wmask             one-hot way to write
//   din_tag           write tag, or compare tag on reads
//   din_dirty         dirty bit written with the tag
//   inv_start         start the invalidate-all walk
//   dout_tag          tags of the registered set, way i at [i*TAG_WIDTH +: TAG_WIDTH]
//   dout_valid/dirty  valid/dirty bits of the registered set
//   hit, hit_way      compare result (reads only)
//   victim_way        lowest invalid way, else the round-robin way
//   busy              invalidate walk in progress
module cache_tag_array_nway #(
  parameter int TAG_WIDTH = 24,
  parameter int SET_BITS  = 4,
  parameter int WAYS      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      csb,
  input  logic                      web,
  input  logic [SET_BITS-1:0]       addr,
  input  logic [WAYS-1:0]           wmask,
  input  logic [TAG_WIDTH-1:0]      din_tag,
  input  logic                      din_dirty,
  input  logic                      inv_start,
  output logic [WAYS*TAG_WIDTH-1:0] dout_tag,
  output logic [WAYS-1:0]           dout_valid,
  output logic [WAYS-1:0]           dout_dirty,
  output logic                      hit,
  output logic [WAYS-1:0]           hit_way,
  output logic [WAYS-1:0]           victim_way,
  output logic                      busy
);
  localparam int DEPTH = 1 << SET_BITS;
  localparam int RR_W  = $clog2(WAYS);
  localparam logic [WAYS-1:0] ONE = 1;

  typedef enum logic {IDLE, WALK} state_t;

  state_t                         state, state_nx;
  logic [SET_BITS-1:0]            cnt, cnt_nx;

  logic                           req_vld_reg, web_reg, din_dirty_reg;
  logic [SET_BITS-1:0]            addr_reg;
  logic [WAYS-1:0]                wmask_reg;
  logic [TAG_WIDTH-1:0]           din_tag_reg;

  logic [TAG_WIDTH-1:0]           tag_mem [DEPTH][WAYS];
  logic [DEPTH-1:0][WAYS-1:0]     valid_q, dirty_q;
  logic [DEPTH-1:0][RR_W-1:0]     rr_ptr;

  logic                           accept, clear_en, commit_ok, undo;
  logic [WAYS-1:0]                view_valid, view_dirty;
  logic                           found;

  assign busy     = (state == WALK);
  assign accept   = ~csb & ~busy;
  assign clear_en = (state == WALK);
  // The walk clear takes priority over a commit to the same set.
  assign commit_ok = req_vld_reg & ~web_reg & (|wmask_reg) &
                     ~(clear_en && cnt == addr_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      req_vld_reg <= 1'b0;
    end else begin
      req_vld_reg <= accept;
      if (accept) begin
        web_reg       <= web;
        addr_reg      <= addr;
        wmask_reg     <= wmask;
        din_tag_reg   <= din_tag;
        din_dirty_reg <= din_dirty;
      end
    end
  end

  // Tags are not reset; a reset-time commit is dropped.
  always_ff @(posedge clk) begin
    if (!rst && commit_ok)
      for (int w = 0; w < WAYS; w++)
        if (wmask_reg[w]) tag_mem[addr_reg][w] <= din_tag_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      rr_ptr  <= '0;
    end else begin
      if (commit_ok) begin
        valid_q[addr_reg] <= valid_q[addr_reg] | wmask_reg;
        dirty_q[addr_reg] <= (dirty_q[addr_reg] & ~wmask_reg) |
                             (din_dirty_reg ? wmask_reg : '0);
        if (wmask_reg == (ONE << rr_ptr[addr_reg]))
          rr_ptr[addr_reg] <= rr_ptr[addr_reg] + 1'b1;
      end
      if (clear_en) begin
        valid_q[cnt] <= '0;
        dirty_q[cnt] <= '0;
        rr_ptr[cnt]  <= '0;
      end
    end
  end

`ifdef TAG_ARRAY_BYPASS_EN
  // Storage is already updated on the commit edge, so the next request
  // naturally observes the write.
  assign undo = 1'b0;
  logic [WAYS-1:0]      pend_mask;
  logic [TAG_WIDTH-1:0] pend_tags [WAYS];
  logic [WAYS-1:0]      pend_valid, pend_dirty;
  assign pend_mask  = '0;
  assign pend_valid = '0;
  assign pend_dirty = '0;
  always_comb for (int w = 0; w < WAYS; w++) pend_tags[w] = '0;
`else
  // Remember the pre-write contents of the last committed row so a request
  // issued right behind the write still sees the old values.
  logic                 pend_vld;
  logic [SET_BITS-1:0]  pend_set;
  logic [WAYS-1:0]      pend_mask, pend_valid, pend_dirty;
  logic [TAG_WIDTH-1:0] pend_tags [WAYS];

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld <= 1'b0;
    end else begin
      pend_vld <= commit_ok;
      if (commit_ok) begin
        pend_set   <= addr_reg;
        pend_mask  <= wmask_reg;
        pend_valid <= valid_q[addr_reg];
        pend_dirty <= dirty_q[addr_reg];
        for (int w = 0; w < WAYS; w++) pend_tags[w] <= tag_mem[addr_reg][w];
      end
    end
  end

  assign undo = pend_vld & req_vld_reg & (pend_set == addr_reg);
`endif

  always_comb begin
    dout_tag   = '0;
    view_valid = '0;
    view_dirty = '0;
    hit_way    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (undo && pend_mask[w]) begin
        dout_tag[w*TAG_WIDTH +: TAG_WIDTH] = pend_tags[w];
        view_valid[w] = pend_valid[w];
        view_dirty[w] = pend_dirty[w];
      end else begin
        dout_tag[w*TAG_WIDTH +: TAG_WIDTH] = tag_mem[addr_reg][w];
        view_valid[w] = valid_q[addr_reg][w];
        view_dirty[w] = dirty_q[addr_reg][w];
      end
      hit_way[w] = req_vld_reg & web_reg & view_valid[w] &
                   (dout_tag[w*TAG_WIDTH +: TAG_WIDTH] == din_tag_reg);
    end
  end

  assign dout_valid = view_valid;
  assign dout_dirty = view_dirty;
  assign hit        = |hit_way;

  always_comb begin
    victim_way = ONE << rr_ptr[addr_reg];
    found      = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!found && !view_valid[w]) begin
        victim_way    = '0;
        victim_way[w] = 1'b1;
        found         = 1'b1;
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (inv_start) begin
        state_nx = WALK;
        cnt_nx   = '0;
      end
      WALK: if (&cnt) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_tag_array_nway.sv
// Directed bench for cache_tag_array_nway (WAYS=4, SET_BITS=4, TAG_WIDTH=24).
// Inputs change on negedge; outputs are sampled on negedge during the
// output cycle of each request.
module tb_cache_tag_array_nway;
  localparam int TW = 24, SB = 4, WY = 4;

  logic             clk = 1'b0;
  logic             rst, csb, web, din_dirty, inv_start;
  logic [SB-1:0]    addr;
  logic [WY-1:0]    wmask;
  logic [TW-1:0]    din_tag;
  logic [WY*TW-1:0] dout_tag;
  logic [WY-1:0]    dout_valid, dout_dirty, hit_way, victim_way;
  logic             hit, busy;

  int checks = 0;
  int failures = 0;

  cache_tag_array_nway #(.TAG_WIDTH(TW), .SET_BITS(SB), .WAYS(WY)) dut (
    .clk(clk), .rst(rst), .csb(csb), .web(web), .addr(addr), .wmask(wmask),
    .din_tag(din_tag), .din_dirty(din_dirty), .inv_start(inv_start),
    .dout_tag(dout_tag), .dout_valid(dout_valid), .dout_dirty(dout_dirty),
    .hit(hit), .hit_way(hit_way), .victim_way(victim_way), .busy(busy)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge inside the output cycle.
  task automatic do_req(input logic we, input logic [SB-1:0] a,
                        input logic [WY-1:0] m, input logic [TW-1:0] t,
                        input logic d);
    csb = 1'b0; web = ~we; addr = a; wmask = m; din_tag = t; din_dirty = d;
    @(negedge clk);
    csb = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; csb = 1'b1; web = 1'b1; addr = '0; wmask = '0;
    din_tag = '0; din_dirty = 1'b0; inv_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hit); end
    checks++; if (hit_way !== 4'b0000) begin failures++; $display("FAIL reset_hit_way got=%b exp=0000", hit_way); end
    checks++; if (dout_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=0000", dout_valid); end
    checks++; if (dout_dirty !== 4'b0000) begin failures++; $display("FAIL reset_dirty got=%b exp=0000", dout_dirty); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (victim_way !== 4'b0001) begin failures++; $display("FAIL reset_victim got=%b exp=0001", victim_way); end
  endtask

  task automatic test_read_miss;
    do_req(1'b0, 4'd3, 4'b0000, 24'hABCDEF, 1'b0);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL miss_hit got=%b exp=0", hit); end
    checks++; if (dout_valid !== 4'b0000) begin failures++; $display("FAIL miss_valid got=%b exp=0000", dout_valid); end
    checks++; if (victim_way !== 4'b0001) begin failures++; $display("FAIL miss_victim got=%b exp=0001", victim_way); end
  endtask

  task automatic test_write_hit;
    do_req(1'b1, 4'd3, 4'b0100, 24'h123456, 1'b1);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL write_cycle_hit got=%b exp=0", hit); end
    @(negedge clk);
    do_req(1'b0, 4'd3, 4'b0000, 24'h123456, 1'b0);
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL wh_hit got=%b exp=1", hit); end
    checks++; if (hit_way !== 4'b0100) begin failures++; $display("FAIL wh_hit_way got=%b exp=0100", hit_way); end
    checks++; if (dout_dirty !== 4'b0100) begin failures++; $display("FAIL wh_dirty got=%b exp=0100", dout_dirty); end
    checks++; if (dout_valid !== 4'b0100) begin failures++; $display("FAIL wh_valid got=%b exp=0100", dout_valid); end
    checks++; if (dout_tag[2*TW +: TW] !== 24'h123456) begin failures++; $display("FAIL wh_tag got=%h exp=123456", dout_tag[2*TW +: TW]); end
    checks++; if (victim_way !== 4'b0001) begin failures++; $display("FAIL wh_victim got=%b exp=0001", victim_way); end
    do_req(1'b0, 4'd3, 4'b0000, 24'h123457, 1'b0);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL wh_wrong_tag got=%b exp=0", hit); end
  endtask

  task automatic test_victim;
    do_req(1'b1, 4'd5, 4'b0001, 24'h500000, 1'b0);
    do_req(1'b1, 4'd5, 4'b0010, 24'h500001, 1'b0);
    do_req(1'b1, 4'd5, 4'b0100, 24'h500002, 1'b0);
    do_req(1'b1, 4'd5, 4'b1000, 24'h500003, 1'b0);
    @(negedge clk);
    do_req(1'b0, 4'd5, 4'b0000, 24'h500003, 1'b0);
    checks++; if (dout_valid !== 4'b1111) begin failures++; $display("FAIL vic_full_valid got=%b exp=1111", dout_valid); end
    checks++; if (victim_way !== 4'b0001) begin failures++; $display("FAIL vic_rr0 got=%b exp=0001", victim_way); end
    checks++; if (hit_way !== 4'b1000) begin failures++; $display("FAIL vic_hit_way got=%b exp=1000", hit_way); end
    do_req(1'b1, 4'd5, 4'b0001, 24'h5AAAAA, 1'b0);
    @(negedge clk);
    do_req(1'b0, 4'd5, 4'b0000, 24'h000000, 1'b0);
    checks++; if (victim_way !== 4'b0010) begin failures++; $display("FAIL vic_rr1 got=%b exp=0010", victim_way); end
    do_req(1'b1, 4'd6, 4'b0001, 24'h600000, 1'b0);
    @(negedge clk);
    do_req(1'b0, 4'd6, 4'b0000, 24'h000000, 1'b0);
    checks++; if (victim_way !== 4'b0010) begin failures++; $display("FAIL vic_lowest_invalid got=%b exp=0010", victim_way); end
    do_req(1'b1, 4'd8, 4'b0000, 24'h800000, 1'b1);
    @(negedge clk);
    do_req(1'b0, 4'd8, 4'b0000, 24'h800000, 1'b0);
    checks++; if (dout_valid !== 4'b0000) begin failures++; $display("FAIL zero_mask_valid got=%b exp=0000", dout_valid); end
  endtask

  task automatic test_back_to_back;
    logic exp_hit;
`ifdef TAG_ARRAY_BYPASS_EN
    exp_hit = 1'b1;
`else
    exp_hit = 1'b0;
`endif
    do_req(1'b1, 4'd7, 4'b0010, 24'h777777, 1'b1);
    do_req(1'b0, 4'd7, 4'b0000, 24'h777777, 1'b0);
    checks++; if (hit !== exp_hit) begin failures++; $display("FAIL b2b_hit got=%b exp=%b", hit, exp_hit); end
    @(negedge clk);
    do_req(1'b0, 4'd7, 4'b0000, 24'h777777, 1'b0);
    checks++; if (hit_way !== 4'b0010) begin failures++; $display("FAIL b2b_later_hit_way got=%b exp=0010", hit_way); end
  endtask

  task automatic test_invalidate;
    int n;
    for (int s = 0; s < 16; s++) do_req(1'b1, 4'(s), 4'b0001, 24'(s + 24'h100), 1'b0);
    @(negedge clk);
    do_req(1'b0, 4'd9, 4'b0000, 24'h000109, 1'b0);
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL fill_hit got=%b exp=1", hit); end
    inv_start = 1'b1;
    @(negedge clk);
    inv_start = 1'b0;
    // Hold a write to set 2 for the whole walk; it must never be accepted.
    csb = 1'b0; web = 1'b0; addr = 4'd2; wmask = 4'b0010; din_tag = 24'hDEAD02;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      inv_start = (n == 3);
      @(negedge clk);
    end
    csb = 1'b1; inv_start = 1'b0;
    checks++; if (n !== 16) begin failures++; $display("FAIL busy_cycles got=%0d exp=16", n); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_walk got=%b exp=0", busy); end
    for (int s = 0; s < 16; s++) begin
      do_req(1'b0, 4'(s), 4'b0000, 24'(s + 24'h100), 1'b0);
      checks++; if (dout_valid !== 4'b0000) begin failures++; $display("FAIL inv_set%0d_valid got=%b exp=0000", s, dout_valid); end
    end
    // Request and inv_start together: request wins, walk follows.
    do_req(1'b1, 4'd4, 4'b1000, 24'h444444, 1'b0);
    @(negedge clk);
    inv_start = 1'b1;
    do_req(1'b0, 4'd4, 4'b0000, 24'h444444, 1'b0);
    inv_start = 1'b0;
    checks++; if (hit_way !== 4'b1000) begin failures++; $display("FAIL req_with_inv_hit_way got=%b exp=1000", hit_way); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL req_with_inv_busy got=%b exp=1", busy); end
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
    checks++; if (n !== 16) begin failures++; $display("FAIL second_walk_cycles got=%0d exp=16", n); end
  endtask

  task automatic test_reset_mid_walk;
    do_req(1'b1, 4'd10, 4'b0001, 24'hAAAAAA, 1'b1);
    do_req(1'b1, 4'd1, 4'b0100, 24'h111111, 1'b0);
    @(negedge clk);
    inv_start = 1'b1;
    @(negedge clk);
    inv_start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_walk_busy got=%b exp=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_walk_busy got=%b exp=0", busy); end
    do_req(1'b0, 4'd10, 4'b0000, 24'hAAAAAA, 1'b0);
    checks++; if (dout_valid !== 4'b0000) begin failures++; $display("FAIL rst_set10_valid got=%b exp=0000", dout_valid); end
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL rst_set10_hit got=%b exp=0", hit); end
    do_req(1'b0, 4'd1, 4'b0000, 24'h111111, 1'b0);
    checks++; if (dout_valid !== 4'b0000) begin failures++; $display("FAIL rst_set1_valid got=%b exp=0000", dout_valid); end
    // A write whose commit edge sees reset is dropped.
    do_req(1'b1, 4'd11, 4'b0001, 24'hBBBBBB, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 4'd11, 4'b0000, 24'hBBBBBB, 1'b0);
    checks++; if (dout_valid !== 4'b0000) begin failures++; $display("FAIL rst_drop_write got=%b exp=0000", dout_valid); end
  endtask

  initial begin
    test_reset;
    test_read_miss;
    test_write_hit;
    test_victim;
    test_back_to_back;
    test_invalidate;
    test_reset_mid_walk;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_tag_array_nway.md
CACHE_TAG_ARRAY_NWAY -- requirements
Module: cache_tag_array_nway

Interface
REQ-001 Parameter TAG_WIDTH, 24, tag bits per way.
REQ-002 Parameter SET_BITS, 4, set index width; DEPTH = 1 << SET_BITS sets.
REQ-003 Parameter WAYS, 4, ways per set; power of two, 2..8.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 csb  in  1  active-low request select.
REQ-007 web  in  1  active-low write (0 = write, 1 = read/compare).
REQ-008 addr  in  SET_BITS  set index.
REQ-009 wmask  in  WAYS  one-hot way to write; ignored on reads.
REQ-010 din_tag  in  TAG_WIDTH  tag to write, or compare tag on reads.
REQ-011 din_dirty  in  1  dirty bit written with the tag.
REQ-012 inv_start  in  1  start invalidate-all walk.
REQ-013 dout_tag  out  WAYS*TAG_WIDTH  tags of the registered set; way i at [i*TAG_WIDTH +: TAG_WIDTH].
REQ-014 dout_valid, dout_dirty  out  WAYS each  valid/dirty bits of the registered set.
REQ-015 hit  out  1; hit_way  out  WAYS one-hot; victim_way  out  WAYS one-hot.
REQ-016 busy  out  1  invalidate walk in progress.

Function
REQ-017 A request is accepted on a posedge when csb=0 and busy=0; this latches web, addr, wmask, din_tag and din_dirty into input registers and sets req_vld_reg=1. Otherwise req_vld_reg=0 and the input registers hold.
REQ-018 Read latency is 1 cycle: dout_* are combinational from the storage entry at addr_reg during the cycle after acceptance.
REQ-019 A write commits on the posedge ending the cycle after acceptance (req_vld_reg=1, web_reg=0). It stores the tag, sets valid=1 and dirty=din_dirty_reg in the wmask_reg way. wmask_reg=0 commits nothing.
REQ-020 During a write's output cycle, dout_* show the pre-write contents; hit and hit_way are forced to 0.
REQ-021 hit_way[i] = req_vld_reg & web_reg & valid[i] & (tag[i]==din_tag_reg); hit = OR of hit_way.
REQ-022 victim_way selects the lowest-index invalid way of the addr_reg set; if all ways are valid, it selects the way given by that set's round-robin pointer rr_ptr (log2(WAYS) bits).
REQ-023 rr_ptr[set] increments modulo WAYS when a write commits to that set with wmask_reg equal to the pointed way.
REQ-024 Invalidate FSM, IDLE -> WALK:
- In IDLE, inv_start=1 sets cnt=0 and moves to WALK.
- In WALK, each cycle clears valid, dirty and rr_ptr of set cnt, then increments cnt.
- At cnt=DEPTH-1 the FSM returns to IDLE.
- busy = (state==WALK); a walk lasts exactly DEPTH cycles.
REQ-025 inv_start is ignored while busy.
REQ-026 inv_start and an accepted request in the same cycle: the request is accepted; the walk starts the next cycle.
REQ-027 A write commit and a walk clear hitting the same set on the same edge: the clear wins for that set. Commits to other sets proceed.
REQ-028 cnt wraps to 0 on return to IDLE; addr_reg is never modified by the walk.

Reset
REQ-029 On rst=1:
- all valid, dirty and rr_ptr bits clear to 0;
- req_vld_reg clears to 0;
- the FSM goes to IDLE with cnt=0;
- tag storage is not reset.
REQ-030 Output values after reset: hit=0, hit_way=0, dout_valid=0, dout_dirty=0, busy=0, victim_way=1 (way 0).
REQ-031 rst asserted mid-walk aborts the walk; rst asserted with a pending write drops the write.

Configuration
REQ-032 Macro TAG_ARRAY_BYPASS_EN.
- Defined: a read accepted in the cycle immediately after a write to the same addr sees the committed write in its output cycle (forwarded tag, valid and dirty for the written way; hit computed on the forwarded values).
- Undefined: that read sees pre-write contents, matching raw SRAM timing.

Verification (WAYS=4, SET_BITS=4, TAG_WIDTH=24)
REQ-033 Reset, then read set 3 tag 0xABCDEF -> hit=0, dout_valid=0000, victim_way=0001.
REQ-034 Write set 3 way 2 tag 0x123456 dirty=1, idle one cycle, then read set 3 tag 0x123456 -> hit=1, hit_way=0100, dout_dirty=0100.
REQ-035 Fill all 4 ways of set 5, then read set 5 -> victim_way=0001; write way 0, read again -> victim_way=0010.
REQ-036 Write set 7 then immediately read set 7 with the same tag -> hit=1 with TAG_ARRAY_BYPASS_EN defined, hit=0 without it.
REQ-037 Fill sets 0..15, pulse inv_start -> busy high exactly 16 cycles; requests during busy are dropped; afterwards every set reads dout_valid=0000.
REQ-038 Assert rst in walk cycle 5 -> busy=0 on the next cycle and all valid bits are 0.
